// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver with sync, clock filter, parity/stop check and watchdog
module ps2_frame_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t state, state_nx;
  logic [1:0] c_sync, d_sync;
  logic [FILTER_LEN-1:0] flt;
  logic fc, fall, start, timeout, done_nx, perr_nx, ferr_nx;
  logic [9:0] sh;
  logic [3:0] n;
  logic [WW-1:0] wd;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
      flt <= '1;
      fc <= 1'b1;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
      flt <= {flt[FILTER_LEN-2:0], c_sync[1]};
      fc <= &flt ? 1'b1 : ~|flt ? 1'b0 : fc;
    end
  // fall is the cycle in which fc is about to drop from 1 to 0
  assign fall = fc & ~|flt;
  assign start = state == IDLE && fall && rx_en && !d_sync[1];
  assign timeout = state == SHIFT && !fall && wd == WW'(TIMEOUT_CYCLES - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (fall && n == 4'd0) state_nx = LOAD;
               else if (timeout) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    done_nx = state == LOAD && sh[9] && ^sh[8:0];
    perr_nx = state == LOAD && sh[9] && !(^sh[8:0]);
    ferr_nx = (state == LOAD && !sh[9]) || timeout;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sh <= '0;
      n <= '0;
      wd <= '0;
      dout <= '0;
      rx_done_tick <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done_tick <= done_nx;
      parity_err <= perr_nx;
      frame_err <= ferr_nx;
      if (done_nx) dout <= sh[7:0];
      if (start) n <= 4'd9;
      if (state != SHIFT) wd <= '0;
      else if (fall) begin
        sh <= {d_sync[1], sh[9:1]};
        wd <= '0;
        if (n != 4'd0) n <= n - 4'd1;
      end else if (timeout) begin
        sh <= '0;
        wd <= '0;
      end else wd <= wd + WW'(1);
    end
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: table-driven frame stimulus with a pulse scoreboard for ps2_frame_rx
module tb_ps2_frame_rx;
  localparam int FL = 8, TO = 200, H = 20;
  localparam logic [2:0] K_NONE = 3'd0, K_DONE = 3'd1, K_PERR = 3'd2, K_FERR = 3'd4;
  logic clk = 1'b0, reset = 1'b0, ps2d = 1'b1, ps2c = 1'b1, rx_en = 1'b1;
  logic [7:0] dout;
  logic rx_done_tick, parity_err, frame_err, busy;
  ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en),
    .dout(dout), .rx_done_tick(rx_done_tick), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {logic [2:0] kind; logic [7:0] dout; int cyc;} ev_t;
  typedef struct {logic [7:0] data; logic pok; logic stop; logic en; int g; logic [2:0] kind;} vec_t;
  ev_t act_q[$], exp_q[$];
  int cyc = 0, busy_cnt = 0, stop_cyc = 0, n_chk = 0, n_fail = 0;
  logic [7:0] exp_dout = 8'h00;
  vec_t tbl[8];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (reset) begin
      if (rx_done_tick | parity_err | frame_err)
        act_q.push_back('{{frame_err, parity_err, rx_done_tick}, dout, cyc});
      if (busy) busy_cnt = busy_cnt + 1;
    end
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick(int k);
    repeat (k) @(negedge clk);
  endtask
  function automatic logic [10:0] frame(logic [7:0] d, logic pok, logic stop);
    return {stop, pok ? ~^d : ^d, d, 1'b0};
  endfunction
  task automatic send(logic [10:0] bits, int nb, int g);
    for (int i = 0; i < nb; i++) begin
      ps2d = bits[i];
      if (i == g) begin
        tick(6); ps2c = 1'b0; tick(3); ps2c = 1'b1; tick(H - 9);
      end else tick(H);
      ps2c = 1'b0;
      if (i == 10) stop_cyc = cyc;
      tick(H);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
  endtask
  task automatic expect_ev(logic [2:0] k, logic [7:0] d);
    ev_t e;
    if (k == K_DONE) exp_dout = d;
    e.kind = k;
    e.dout = exp_dout;
    e.cyc = 0;
    exp_q.push_back(e);
  endtask
  task automatic check_ev(string nm);
    ev_t e, a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.kind == K_NONE) chk({nm, " no pulse"}, act_q.size(), 0);
      else begin
        chk({nm, " pulse count"}, act_q.size(), 1);
        if (act_q.size() > 0) begin
          a = act_q.pop_front();
          chk({nm, " latency"}, int'(a.cyc - stop_cyc >= 11 && a.cyc - stop_cyc <= 13), 1);
          chk({nm, " kind"}, a.kind, e.kind);
          chk({nm, " dout"}, a.dout, e.dout);
        end
      end
    end
    act_q.delete();
    chk({nm, " busy idle"}, busy, 0);
    chk({nm, " dout hold"}, dout, exp_dout);
  endtask
  task automatic run_vec(vec_t v, string nm);
    int b0;
    rx_en = v.en;
    b0 = busy_cnt;
    if (v.g >= 0) begin
      ps2d = 1'b0; tick(2); ps2c = 1'b0; tick(3); ps2c = 1'b1; tick(H); ps2d = 1'b1; tick(H);
    end
    expect_ev(v.kind, v.data);
    send(frame(v.data, v.pok, v.stop), 11, v.g);
    tick(60);
    check_ev(nm);
    chk({nm, " busy seen"}, int'(busy_cnt > b0), int'(v.en));
  endtask
  initial begin
    tbl[0] = '{8'h1C, 1'b1, 1'b1, 1'b1, -1, K_DONE};
    tbl[1] = '{8'h1C, 1'b0, 1'b1, 1'b1, -1, K_PERR};
    tbl[2] = '{8'hF0, 1'b1, 1'b1, 1'b1, -1, K_DONE};
    tbl[3] = '{8'h5A, 1'b0, 1'b0, 1'b1, -1, K_FERR};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 1'b1, 4, K_DONE};
    tbl[5] = '{8'h00, 1'b1, 1'b1, 1'b1, -1, K_DONE};
    tbl[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, -1, K_DONE};
    tbl[7] = '{8'h1C, 1'b1, 1'b1, 1'b0, -1, K_NONE};
    tick(3);
    chk("reset dout", dout, 0);
    chk("reset done", rx_done_tick, 0);
    chk("reset perr", parity_err, 0);
    chk("reset ferr", frame_err, 0);
    chk("reset busy", busy, 0);
    reset = 1'b1;
    tick(20);
    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    rx_en = 1'b1;
    expect_ev(K_FERR, 8'h00);
    send(frame(8'h29, 1'b1, 1'b1), 5, -1);
    chk("timeout busy mid", busy, 1);
    tick(TO + 60);
    stop_cyc = act_q.size() > 0 ? act_q[0].cyc - 12 : 0;
    check_ev("timeout");
    run_vec('{8'h29, 1'b1, 1'b1, 1'b1, -1, K_DONE}, "after timeout");
    send(frame(8'h1C, 1'b1, 1'b1), 5, -1);
    chk("midframe busy", busy, 1);
    reset = 1'b0;
    exp_dout = 8'h00;
    tick(2);
    chk("mid reset dout", dout, 0);
    chk("mid reset busy", busy, 0);
    chk("mid reset pulses", {rx_done_tick, parity_err, frame_err}, 0);
    tick(3);
    reset = 1'b1;
    expect_ev(K_NONE, 8'h00);
    tick(50);
    check_ev("mid reset");
    run_vec('{8'h1C, 1'b1, 1'b1, 1'b1, -1, K_DONE}, "after reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
